// File: rtl/pe_pkg.sv
// Shared constants and types for the PE result requantizer.
package pe_pkg;

  // Fixed-point formats on either side of the requantizer
  localparam int Q1616_W    = 32;
  localparam int Q1616_FRAC = 16;
  localparam int Q88_W      = 16;
  localparam int Q88_FRAC   = 8;

  // Q8.8 representable range, used as the saturation bounds
  localparam int Q88_MAX = 32767;
  localparam int Q88_MIN = -32768;

  // Group state: no open group, or a group collecting beats
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } req_state_e;

  // One output FIFO word: saturation flag plus the Q8.8 value
  typedef struct packed {
    logic             sat;
    logic [Q88_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/pe_out_fifo.sv
// Small synchronous FIFO for requantized words. A push into a full FIFO is
// still accepted when a pop happens in the same cycle; otherwise it is
// dropped and reported on drop_o. When empty, head_o keeps presenting the
// most recently popped word so the output bus does not glitch.
module pe_out_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        drop_o
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t       mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] last_addr;
  logic              do_push;
  logic              do_pop;

  assign rd_addr   = rd_ptr_q[ADDR_W-1:0];
  assign last_addr = rd_addr - ADDR_W'(1);

  // Flags, accepted push/pop and next pointers
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    drop_o   = push_i && !do_push;
    wr_ptr_d = wr_ptr_q + (do_push ? (ADDR_W+1)'(1) : '0);
    rd_ptr_d = rd_ptr_q + (do_pop ? (ADDR_W+1)'(1) : '0);
    head_o   = empty_o ? mem_q[last_addr] : mem_q[rd_addr];
  end

  // Storage and pointer registers; storage is cleared so the idle head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pe_result_requant.sv
// Downstream of the PE: groups consecutive Q16.16 results into sums, rounds
// and saturates each sum to Q8.8, and queues the words for the next stage.
// The PE cannot be stalled, so a full queue drops words and raises ovf_err.
module pe_result_requant
  import pe_pkg::*;
#(
  parameter int IN_WIDTH   = Q1616_W,
  parameter int OUT_WIDTH  = Q88_W,
  parameter int FRAC_SHIFT = Q1616_FRAC - Q88_FRAC,
  parameter int SUM_WIDTH  = 40,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 ovf_err,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam logic signed [SUM_WIDTH-1:0] ROUND_BIAS = SUM_WIDTH'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX    = SUM_WIDTH'(Q88_MAX);
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN    = SUM_WIDTH'(Q88_MIN);

  req_state_e                  state_q, state_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [LEN_WIDTH-1:0]        count_q, count_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic                        ovf_err_q, ovf_err_d;

  logic signed [SUM_WIDTH-1:0] beat_ext;
  logic signed [SUM_WIDTH-1:0] total;
  logic signed [SUM_WIDTH-1:0] rounded;
  logic                        close_grp;
  fifo_entry_t                 push_word;
  fifo_entry_t                 head_word;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        fifo_drop;

  assign beat_ext = {{(SUM_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

  // Group FSM: accumulate beats, decide when the group closes
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    count_d   = count_q;
    len_d     = len_q;
    total     = sum_q;
    close_grp = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // cfg_len is only looked at here, so mid-group changes are ignored
          len_d     = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
          count_d   = LEN_WIDTH'(1);
          total     = beat_ext;
          close_grp = flush || (len_d == LEN_WIDTH'(1));
        end
      end
      ACCUM: begin
        total     = in_valid ? (sum_q + beat_ext) : sum_q;
        count_d   = count_q + (in_valid ? LEN_WIDTH'(1) : '0);
        close_grp = flush || (in_valid && (count_d == len_q));
      end
      default: ;
    endcase
    if (in_valid || state_q == ACCUM) begin
      sum_d   = total;
      state_d = close_grp ? IDLE : ACCUM;
    end
    if (close_grp) begin
      sum_d   = '0;
      count_d = '0;
    end
  end

  // Round half up, then clamp into the Q8.8 range
  always_comb begin
    rounded        = (total + ROUND_BIAS) >>> FRAC_SHIFT;
    push_word.sat  = 1'b0;
    push_word.data = rounded[Q88_W-1:0];
    if (rounded > SAT_MAX) begin
      push_word.sat  = 1'b1;
      push_word.data = SAT_MAX[Q88_W-1:0];
    end else if (rounded < SAT_MIN) begin
      push_word.sat  = 1'b1;
      push_word.data = SAT_MIN[Q88_W-1:0];
    end
  end

  // Sticky overflow flag; a drop in the same cycle as err_clr wins
  always_comb begin
    ovf_err_d = ovf_err_q;
    if (fifo_drop) begin
      ovf_err_d = 1'b1;
    end else if (err_clr) begin
      ovf_err_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      count_q   <= '0;
      len_q     <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      len_q     <= len_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  pe_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (close_grp),
    .push_data_i (push_word),
    .pop_i       (out_ready),
    .head_o      (head_word),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .drop_o      (fifo_drop)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_word.data;
  assign out_sat   = head_word.sat;
  assign ovf_err   = ovf_err_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_pe_result_requant.sv
// Directed bench for pe_result_requant: each task drives one scenario and
// compares outputs against hand-computed Q8.8 values.
module tb_pe_result_requant;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  cfg_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        ovf_err;
  logic        err_clr;
  logic        busy;

  int checks;
  int failures;

  pe_result_requant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_len   (cfg_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle input beat
  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    $display("beat in_data=%h -> out_valid=%0b out_data=%h sat=%0b busy=%0b ovf=%0b",
             d, out_valid, out_data, out_sat, busy, ovf_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, out_data, out_sat, ovf_err, busy} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%0b data=%h sat=%0b ovf=%0b busy=%0b, expected all 0",
               out_valid, out_data, out_sat, ovf_err, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_len1();
    out_ready = 1'b1;
    cfg_len   = 8'd1;
    beat(32'h0001_8000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0180 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL len1_word: got valid=%0b data=%h sat=%0b, expected 1 0180 0",
               out_valid, out_data, out_sat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL len1_pop: got valid=%0b, expected 0", out_valid);
    end
  endtask

  // Back-to-back single-beat groups (cfg_len=0 acts as 1) exercise rounding
  task automatic test_rounding();
    logic [31:0] vin [3];
    logic [15:0] vexp [3];
    vin[0] = 32'h0000_0080; vexp[0] = 16'h0001;
    vin[1] = 32'hFFFF_FF80; vexp[1] = 16'h0000;
    vin[2] = 32'hFFFF_FF7F; vexp[2] = 16'hFFFF;
    out_ready = 1'b1;
    cfg_len   = 8'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      tick();
      $display("round in_data=%h -> out_valid=%0b out_data=%h", vin[i], out_valid, out_data);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_sat !== 1'b0) begin
        failures++;
        $display("FAIL round_%0d: got valid=%0b data=%h sat=%0b, expected 1 %h 0",
                 i, out_valid, out_data, out_sat, vexp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL round_drain: got valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] vin [2];
    logic [15:0] vexp [2];
    vin[0] = 32'h7000_0000; vexp[0] = 16'h7FFF;
    vin[1] = 32'h9000_0000; vexp[1] = 16'h8000;
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      cfg_len = 8'd4;
      beat(vin[g]);
      cfg_len = 8'd1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sat_open_%0d: got busy=%0b valid=%0b, expected 1 0", g, busy, out_valid);
      end
      beat(vin[g]);
      beat(vin[g]);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sat_early_%0d: got valid=%0b, expected 0", g, out_valid);
      end
      beat(vin[g]);
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[g] || out_sat !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL sat_word_%0d: got valid=%0b data=%h sat=%0b busy=%0b, expected 1 %h 1 0",
                 g, out_valid, out_data, out_sat, busy, vexp[g]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    cfg_len   = 8'd3;
    beat(32'h0001_0000);
    beat(32'h0001_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0200 || out_sat !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_word: got valid=%0b data=%h sat=%0b busy=%0b, expected 1 0200 0 0",
               out_valid, out_data, out_sat, busy);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: got valid=%0b busy=%0b, expected 0 0", out_valid, busy);
    end
    cfg_len = 8'd2;
    beat(32'h0001_0000);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_newgrp_open: got busy=%0b valid=%0b, expected 1 0", busy, out_valid);
    end
    beat(32'h0002_0000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0300) begin
      failures++;
      $display("FAIL flush_newgrp_word: got valid=%0b data=%h, expected 1 0300", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    for (int k = 1; k <= 5; k++) begin
      beat(32'(k) << 16);
      if (k == 4) begin
        checks++;
        if (ovf_err !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early: got ovf=%0b, expected 0", ovf_err);
        end
      end
    end
    checks++;
    if (ovf_err !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got ovf=%0b valid=%0b, expected 1 1", ovf_err, out_valid);
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      $display("drain word %0d out_data=%h", k, out_data);
      checks++;
      if (out_valid !== 1'b1 || out_data !== (16'(k) << 8)) begin
        failures++;
        $display("FAIL ovf_drain_%0d: got valid=%0b data=%h, expected 1 %h",
                 k, out_valid, out_data, 16'(k) << 8);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0400 || ovf_err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_empty: got valid=%0b data=%h ovf=%0b, expected 0 0400 1",
               out_valid, out_data, ovf_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%0b, expected 0", ovf_err);
    end
  endtask

  // Full FIFO with a push and a pop in the same cycle must lose nothing
  task automatic test_back_to_back();
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    for (int k = 6; k <= 9; k++) begin
      beat(32'(k) << 16);
    end
    out_ready = 1'b1;
    beat(32'h000A_0000);
    checks++;
    if (ovf_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_drop: got ovf=%0b, expected 0", ovf_err);
    end
    for (int k = 7; k <= 10; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== (16'(k) << 8)) begin
        failures++;
        $display("FAIL b2b_order_%0d: got valid=%0b data=%h, expected 1 %h",
                 k, out_valid, out_data, 16'(k) << 8);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty: got valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midgroup();
    out_ready = 1'b0;
    cfg_len   = 8'd1;
    beat(32'h0001_0000);
    beat(32'h0002_0000);
    cfg_len = 8'd3;
    beat(32'h0005_0000);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got busy=%0b valid=%0b, expected 1 1", busy, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ovf_err !== 1'b0 || out_data !== 16'h0000) begin
      failures++;
      $display("FAIL rst_async: got valid=%0b busy=%0b ovf=%0b data=%h, expected 0 0 0 0000",
               out_valid, busy, ovf_err, out_data);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cfg_len   = 8'd2;
    beat(32'h0001_0000);
    beat(32'h0001_0000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0200 || out_sat !== 1'b0) begin
      failures++;
      $display("FAIL rst_newgrp: got valid=%0b data=%h sat=%0b, expected 1 0200 0",
               out_valid, out_data, out_sat);
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_len   = 8'd1;
    flush     = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    test_reset();
    test_len1();
    test_rounding();
    test_saturate();
    test_flush();
    test_overflow();
    test_back_to_back();
    test_reset_midgroup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_result_requant.md
Name: pe_result_requant

Overview:
- Downstream stage of the unified MAC/EWM/EWA PE. Consumes the PE's registered Q16.16 result stream.
- Optionally sums a configurable number of consecutive results (dot-product reduction across PE passes).
- Rounds and saturates each group sum to Q8.8 and buffers the words in a small FIFO with valid/ready toward the next stage (state-update / writeback).
- The PE has no backpressure, so this block absorbs output stalls and flags any loss.

Parameters:
- IN_WIDTH, 32, input result width (Q16.16)
- OUT_WIDTH, 16, output width (Q8.8)
- FRAC_SHIFT, 8, right shift from Q16.16 to Q8.8
- SUM_WIDTH, 40, internal group accumulator width
- LEN_WIDTH, 8, width of group-length config
- FIFO_DEPTH, 4, output FIFO entries (power of 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  PE valid_out; no ready returned
- in_data  in  IN_WIDTH  PE result_out, signed Q16.16
- cfg_len  in  LEN_WIDTH  results per group; 0 treated as 1; sampled on first beat of a group
- flush  in  1  close the current group early and emit its partial sum
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  OUT_WIDTH  signed Q8.8 result
- out_sat  out  1  head word was saturated
- ovf_err  out  1  sticky: a word was dropped because the FIFO was full
- err_clr  in  1  clears ovf_err
- busy  out  1  a group is open (state ACCUM)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, sum=0, count=0, FIFO empty, out_valid=0, out_data=0, out_sat=0, ovf_err=0, busy=0.
- States: IDLE (no open group) and ACCUM (group open).
- Beat handling:
  - A beat is any cycle with in_valid=1. It is always accepted.
  - A beat in IDLE latches len = max(cfg_len,1), sets count=1 and sum=sext(in_data).
  - A beat in ACCUM does sum += sext(in_data) and count++.
  - The group closes on the beat where count reaches len. A group of len 1 closes on its first beat.
- Flush:
  - flush in ACCUM closes the group. The sum includes in_data if in_valid is high in the same cycle.
  - flush in IDLE with in_valid=1 closes a 1-beat group.
  - flush in IDLE with in_valid=0 does nothing.
- On close:
  - Compute total = (current sum including this beat's data).
  - Compute r = (total + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is round-half-up, arithmetic shift.
  - Clamp r to [-32768, 32767]. sat=1 if clamped.
  - Push {sat, r[15:0]} to the FIFO and return to IDLE. busy falls next cycle.
- Latency: closing beat at cycle N gives out_valid=1 at cycle N+1 when the FIFO was empty. Back-to-back len=1 groups sustain 1 word per cycle.
- FIFO: pop when out_valid && out_ready. out_data and out_sat show the head combinationally from FIFO storage. Word order is strictly preserved.
- Full FIFO:
  - Push with no pop in the same cycle: the word is dropped and ovf_err is set the next cycle.
  - Push and pop in the same cycle: allowed, no loss.
- Empty FIFO: out_valid=0 and out_data holds its last value. Consumers must ignore out_data while out_valid=0.
- err_clr: clears ovf_err. If a drop happens in the same cycle, set wins.
- cfg_len changes mid-group are ignored until the next group.
- Width: SUM_WIDTH=40 covers 255 full-scale Q16.16 beats with no internal wrap.

Decomposition:
- pe_pkg holds:
  - Q8.8 and Q16.16 width/fraction constants
  - Q8.8 min/max localparams
  - state enum typedef {IDLE, ACCUM}
  - the FIFO entry struct {sat, data}
- One sub-module, pe_out_fifo: a synchronous FIFO with depth FIFO_DEPTH, full/empty flags, and simultaneous push/pop support when full.

Test Plan:
- len=1, in_data=0x0001_8000 (1.5) -> next cycle out_valid=1, out_data=0x0180, out_sat=0.
- len=1, rounding:
  - 0x0000_0080 -> 0x0001.
  - 0xFFFF_FF80 -> 0x0000.
  - 0xFFFF_FF7F -> 0xFFFF.
- len=4, four beats of 0x7000_0000 -> out_data=0x7FFF, out_sat=1. Four beats of 0x9000_0000 -> 0x8000, out_sat=1.
- len=3, beats 0x0001_0000 and 0x0001_0000, then flush with in_valid=0 -> out_data=0x0200, busy=0 next cycle. A following beat starts a new group.
- out_ready=0, five len=1 groups -> four words held, ovf_err=1 after the fifth. Then out_ready=1 -> the four words drain in order. err_clr -> ovf_err=0.
- Reset asserted mid-group, with two words in the FIFO -> out_valid=0, busy=0, ovf_err=0 immediately. After release, a new len=2 group sums from zero.
